demux1to2_buf: RTL and testbench

DEMUX1TO2_BUF -- requirements
Module: demux1to2_buf

---
 rtl/demux1to2_buf.sv | 103 ++++++++++
 tb/tb_demux1to2_buf.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/demux1to2_buf.sv
// 1-to-2 demultiplexer with a small FIFO per output and valid/ready handshakes.
// Each side also keeps an 8-bit wrapping count of the words it has delivered.
module demux1to2_buf #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             Sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] A,
  output logic             A_valid,
  input  logic             A_ready,
  output logic [WIDTH-1:0] B,
  output logic             B_valid,
  input  logic             B_ready,
  output logic [7:0]       cnt_A,
  output logic [7:0]       cnt_B
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Index 0 is side A, index 1 is side B.
  logic [1:0]            full_s;
  logic [1:0]            valid_s;
  logic [1:0]            ready_s;
  logic [1:0]            push_s;
  logic [1:0]            pop_s;
  logic [1:0][WIDTH-1:0] head_s;
  logic [7:0]            cnt_a_r;
  logic [7:0]            cnt_b_r;

  // A pop in the same cycle never frees a slot for the push: no bypass.
  assign in_ready = Sel ? ~full_s[1] : ~full_s[0];
  assign push_s   = {in_valid & in_ready & Sel, in_valid & in_ready & ~Sel};
  assign ready_s  = {B_ready, A_ready};
  assign pop_s    = valid_s & ready_s;

  for (genvar s = 0; s < 2; s++) begin : g_fifo
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    // Storage is never cleared; only the pointers and count define the content.
    always_ff @(posedge clk) begin
      if (push_s[s] && !rst) begin
        mem_r[wr_ptr_r] <= D;
      end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_r <= AW'(0);
        rd_ptr_r <= AW'(0);
        count_r  <= CW'(0);
      end else begin
        if (push_s[s]) begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
        end
        if (pop_s[s]) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end
        case ({push_s[s], pop_s[s]})
          2'b10:   count_r <= count_r + CW'(1);
          2'b01:   count_r <= count_r - CW'(1);
          default: count_r <= count_r;
        endcase
      end
    end

    assign full_s[s]  = (count_r == CW'(DEPTH));
    assign valid_s[s] = (count_r != CW'(0)) && !rst;
    assign head_s[s]  = valid_s[s] ? mem_r[rd_ptr_r] : WIDTH'(0);
  end

  // Delivered-word counters, wrapping at 8 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_r <= 8'd0;
      cnt_b_r <= 8'd0;
    end else begin
      if (pop_s[0]) begin
        cnt_a_r <= cnt_a_r + 8'd1;
      end
      if (pop_s[1]) begin
        cnt_b_r <= cnt_b_r + 8'd1;
      end
    end
  end

  assign A       = head_s[0];
  assign B       = head_s[1];
  assign A_valid = valid_s[0];
  assign B_valid = valid_s[1];
  assign cnt_A   = cnt_a_r;
  assign cnt_B   = cnt_b_r;

endmodule

// File: tb/tb_demux1to2_buf.sv
// Directed bench for demux1to2_buf (WIDTH=2, DEPTH=2) with immediate-assertion checks.
module tb_demux1to2_buf;

  logic       clk;
  logic       rst;
  logic [1:0] D;
  logic       Sel;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] A;
  logic       A_valid;
  logic       A_ready;
  logic [1:0] B;
  logic       B_valid;
  logic       B_ready;
  logic [7:0] cnt_A;
  logic [7:0] cnt_B;

  int total = 0;
  int bad   = 0;

  demux1to2_buf #(.WIDTH(2), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .D(D), .Sel(Sel), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .A_valid(A_valid), .A_ready(A_ready),
    .B(B), .B_valid(B_valid), .B_ready(B_ready),
    .cnt_A(cnt_A), .cnt_B(cnt_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; D = 2'd0; Sel = 1'b0; in_valid = 1'b0; A_ready = 1'b0; B_ready = 1'b0;
    tick(); tick();
    chk("rst_a_valid", 32'(A_valid), 0);
    chk("rst_b_valid", 32'(B_valid), 0);
    chk("rst_a_data", 32'(A), 0);
    chk("rst_cnt_a", 32'(cnt_A), 0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 1);

    // single word to A
    D = 2'b10; Sel = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("one_a_valid", 32'(A_valid), 1);
    chk("one_a_data", 32'(A), 2);
    chk("one_b_valid", 32'(B_valid), 0);
    chk("one_b_data", 32'(B), 0);
    A_ready = 1'b1;
    tick();
    A_ready = 1'b0;
    chk("one_cnt_a", 32'(cnt_A), 1);
    chk("one_a_empty_data", 32'(A), 0);

    // fill A while stalled
    D = 2'd1; Sel = 1'b0; in_valid = 1'b1; tick();
    D = 2'd2; tick();
    D = 2'd3;
    #1 chk("full_in_ready", 32'(in_ready), 0);
    Sel = 1'b1;
    #1 chk("other_side_in_ready", 32'(in_ready), 1);
    // full FIFO with a simultaneous pop: no bypass
    Sel = 1'b0; A_ready = 1'b1;
    #1 chk("no_bypass_in_ready", 32'(in_ready), 0);
    chk("head_first", 32'(A), 1);
    tick();
    A_ready = 1'b0;
    chk("head_second", 32'(A), 2);
    chk("after_pop_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("stable_head", 32'(A), 2);
    A_ready = 1'b1;
    tick();
    chk("head_third", 32'(A), 3);
    tick();
    A_ready = 1'b0;
    chk("drained_a_valid", 32'(A_valid), 0);
    chk("drained_cnt_a", 32'(cnt_A), 4);

    // alternating stream, both sinks ready
    rst = 1'b1; tick(); rst = 1'b0;
    A_ready = 1'b1; B_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Sel = i[0]; D = i[1:0]; in_valid = 1'b1;
      #1 chk("alt_in_ready", 32'(in_ready), 1);
      tick();
      if (i[0]) begin
        chk("alt_b_data", 32'(B), 32'(i[1:0]));
      end else begin
        chk("alt_a_data", 32'(A), 32'(i[1:0]));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("alt_cnt_a", 32'(cnt_A), 4);
    chk("alt_cnt_b", 32'(cnt_B), 4);

    // 256 words to B: counter wrap
    rst = 1'b1; tick(); rst = 1'b0;
    A_ready = 1'b1; B_ready = 1'b1; Sel = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      D = i[1:0];
      tick();
    end
    in_valid = 1'b0;
    chk("wrap_cnt_b_255", 32'(cnt_B), 255);
    tick();
    chk("wrap_cnt_b_0", 32'(cnt_B), 0);
    chk("wrap_cnt_a", 32'(cnt_A), 0);

    // reset with both FIFOs holding one word and traffic active
    A_ready = 1'b0; B_ready = 1'b0;
    D = 2'd1; Sel = 1'b0; in_valid = 1'b1; tick();
    D = 2'd2; Sel = 1'b1; tick();
    chk("pre_rst_a_valid", 32'(A_valid), 1);
    chk("pre_rst_b_data", 32'(B), 2);
    rst = 1'b1; D = 2'd3; Sel = 1'b0; A_ready = 1'b1; B_ready = 1'b1;
    #1 chk("in_rst_a_data", 32'(A), 0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_flush_a_valid", 32'(A_valid), 0);
    chk("rst_flush_b_valid", 32'(B_valid), 0);
    chk("rst_flush_cnt_a", 32'(cnt_A), 0);
    chk("rst_flush_cnt_b", 32'(cnt_B), 0);
    #1 chk("rst_flush_in_ready", 32'(in_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
